// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding and widths.
package rr_arbiter_8_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arbiter_8_decoder_3x8.sv
// 3-to-8 decoder with enable: A is the MSB of the select, C the LSB.
module decoder_3x8 (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic en,
   output logic d0,
   output logic d1,
   output logic d2,
   output logic d3,
   output logic d4,
   output logic d5,
   output logic d6,
   output logic d7
);

   logic [2:0] sel;

   assign sel = {a, b, c};

   assign d0 = en && (sel == 3'd0);
   assign d1 = en && (sel == 3'd1);
   assign d2 = en && (sel == 3'd2);
   assign d3 = en && (sel == 3'd3);
   assign d4 = en && (sel == 3'd4);
   assign d5 = en && (sel == 3'd5);
   assign d6 = en && (sel == 3'd6);
   assign d7 = en && (sel == 3'd7);

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters. The winner is registered as index plus
// enable and decoded to a one-hot grant, with a hold-time watchdog that forces
// release after MAX_HOLD cycles (0 disables it).
module rr_arbiter_8
   import rr_arbiter_8_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] grant_idx,
   output logic       grant_en,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       timeout
);

   localparam bit WDOG_EN = (MAX_HOLD != 0);
   // Last legal hold count; only meaningful when the watchdog is enabled.
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

   state_t            state, state_n;
   logic [IDX_W-1:0]  ptr, ptr_n;
   logic [IDX_W-1:0]  idx_n;
   logic              en_n;
   logic [CNT_W-1:0]  hold_cnt, hold_n;
   logic              to_n;

   // Scan ptr, ptr+1, ... with 3-bit wrap and return the first requester found.
   function automatic logic [IDX_W-1:0] pick_first(input logic [N_REQ-1:0] r,
                                                   input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      logic             found;
      idx   = p;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = p + IDX_W'(i);
         if (!found && r[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   // Next-state logic: arbitrate in IDLE, hold and watch for release in GRANT.
   always_comb begin
      state_n = state;
      idx_n   = grant_idx;
      en_n    = grant_en;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      to_n    = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               idx_n   = pick_first(req, ptr);
               en_n    = 1'b1;
               hold_n  = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            // Normal release wins over the watchdog when both fire together.
            if (done || !req[grant_idx]) begin
               en_n    = 1'b0;
               state_n = IDLE;
               ptr_n   = grant_idx + 1'b1;
               hold_n  = '0;
            end else if (WDOG_EN && (hold_cnt == HOLD_LAST)) begin
               en_n    = 1'b0;
               state_n = IDLE;
               ptr_n   = grant_idx + 1'b1;
               hold_n  = '0;
               to_n    = 1'b1;
            end else if (hold_cnt != '1) begin
               hold_n  = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            en_n    = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant_idx <= '0;
         grant_en  <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_n;
         grant_idx <= idx_n;
         grant_en  <= en_n;
         ptr       <= ptr_n;
         hold_cnt  <= hold_n;
         timeout   <= to_n;
      end
   end

   assign busy = grant_en;

   decoder_3x8 u_dec (
      .a  (grant_idx[2]),
      .b  (grant_idx[1]),
      .c  (grant_idx[0]),
      .en (grant_en),
      .d0 (gnt[0]),
      .d1 (gnt[1]),
      .d2 (gnt[2]),
      .d3 (gnt[3]),
      .d4 (gnt[4]),
      .d5 (gnt[5]),
      .d6 (gnt[6]),
      .d7 (gnt[7])
   );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: the driver steps a behavioural model and
// queues the expected outputs; a monitor compares them after each clock edge.
module tb_rr_arbiter_8;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic       done;
   logic [2:0] grant_idx;
   logic       grant_en;
   logic [7:0] gnt;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   logic [13:0] exp_q[$];
   logic [13:0] mon_e, mon_a;

   // Reference model: owner index (-1 = nobody), rotating priority start, hold age.
   int m_owner;
   int m_ptr;
   int m_hold;
   int m_last;
   bit m_to;

   always #5 clk = ~clk;

   rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .done      (done),
      .grant_idx (grant_idx),
      .grant_en  (grant_en),
      .gnt       (gnt),
      .busy      (busy),
      .timeout   (timeout)
   );

   function automatic logic [13:0] pack(input logic [2:0] i, input logic e,
                                        input logic [7:0] g, input logic b, input logic t);
      return {i, e, g, b, t};
   endfunction

   function automatic void model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_last  = 0;
      m_to    = 1'b0;
   endfunction

   // Apply one clock edge with the given inputs to the model.
   function automatic void model_step(input logic [7:0] r, input logic d);
      bit found;
      if (m_owner < 0) begin
         m_to  = 1'b0;
         found = 1'b0;
         for (int i = 0; i < 8; i++) begin
            int k;
            k = (m_ptr + i) % 8;
            if (!found && r[k]) begin
               found   = 1'b1;
               m_owner = k;
               m_last  = k;
               m_hold  = 0;
            end
         end
      end else if (d || !r[m_owner]) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
         m_hold  = 0;
         m_to    = 1'b0;
      end else if (MAXH != 0 && m_hold == MAXH - 1) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
         m_hold  = 0;
         m_to    = 1'b1;
      end else begin
         if (m_hold < 255) m_hold++;
         m_to = 1'b0;
      end
   endfunction

   function automatic logic [13:0] model_out();
      logic       e;
      logic [7:0] g;
      e = (m_owner >= 0);
      g = e ? 8'(1 << m_owner) : 8'h00;
      return pack(3'(m_last), e, g, e, m_to);
   endfunction

   task automatic cycle(input logic [7:0] r, input logic d);
      @(negedge clk);
      req  = r;
      done = d;
      model_step(r, d);
      exp_q.push_back(model_out());
   endtask

   task automatic check_now(input string name, input logic [13:0] act, input logic [13:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual idx=%0d en=%b gnt=%h busy=%b to=%b, required idx=%0d en=%b gnt=%h busy=%b to=%b",
                  name, act[13:11], act[10], act[9:2], act[1], act[0],
                  exp[13:11], exp[10], exp[9:2], exp[1], exp[0]);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation after each edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = pack(grant_idx, grant_en, gnt, busy, timeout);
         check_now("cycle_out", mon_a, mon_e);
      end
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: actual still running, required finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [7:0] r;
      logic       d;
      int         drain;

      // Reset and idle.
      model_reset();
      reset = 1'b1;
      req   = 8'h00;
      done  = 1'b0;
      @(posedge clk);
      #1;
      check_now("reset_state", pack(grant_idx, grant_en, gnt, busy, timeout), pack(3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b0;
      repeat (5) cycle(8'h00, 1'b0);

      // Single requester 4, released by done.
      cycle(8'h10, 1'b0);
      cycle(8'h10, 1'b0);
      cycle(8'h10, 1'b0);
      cycle(8'h10, 1'b1);
      cycle(8'h00, 1'b0);
      cycle(8'h00, 1'b0);

      // All requesting, done on the second cycle of every grant.
      repeat (9) begin
         cycle(8'hFF, 1'b0);
         cycle(8'hFF, 1'b0);
         cycle(8'hFF, 1'b1);
      end
      cycle(8'h00, 1'b0);

      // Wrap: after owner 6 releases, requester 0 beats 6.
      cycle(8'h40, 1'b0);
      cycle(8'h40, 1'b1);
      cycle(8'h41, 1'b0);
      cycle(8'h41, 1'b1);
      cycle(8'h41, 1'b0);
      cycle(8'h41, 1'b1);
      cycle(8'h00, 1'b0);

      // Watchdog forced release, then done coinciding with the watchdog.
      repeat (6) cycle(8'h04, 1'b0);
      repeat (3) cycle(8'h04, 1'b0);
      cycle(8'h04, 1'b1);
      cycle(8'h00, 1'b0);
      cycle(8'h00, 1'b0);

      // Asynchronous reset while requester 3 owns the grant.
      cycle(8'h08, 1'b0);
      cycle(8'h08, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_now("async_reset", pack(grant_idx, grant_en, gnt, busy, timeout), pack(3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
      model_reset();
      req = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      cycle(8'h08, 1'b0);
      cycle(8'h08, 1'b1);
      cycle(8'h00, 1'b0);

      // Randomized traffic.
      r = 8'h00;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) != 0) r = 8'($urandom) & 8'($urandom);
         d = ($urandom_range(0, 4) == 0);
         cycle(r, d);
      end
      cycle(8'h00, 1'b0);

      // Let the monitor consume what is still queued.
      drain = 0;
      while (exp_q.size() > 0 && drain < 5) begin
         @(posedge clk);
         #2;
         drain++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: actual %0d pending, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
